// File: rtl/imm_extend.sv
// Immediate extender: builds the sign-extended XLEN immediate for a given
// immediate class from the instruction's upper bits.
`timescale 1ns/1ps

module imm_extend #(
   parameter int unsigned XLEN = 64
) (
   input  logic [31:7]     instr,
   input  logic [2:0]      immsrc,
   output logic [XLEN-1:0] imm
);

   localparam logic [2:0] SRC_I  = 3'd0;
   localparam logic [2:0] SRC_S  = 3'd1;
   localparam logic [2:0] SRC_B  = 3'd2;
   localparam logic [2:0] SRC_U  = 3'd3;
   localparam logic [2:0] SRC_J  = 3'd4;
   localparam logic [2:0] SRC_SH = 3'd5;

   logic signed [11:0] imm_i;
   logic signed [11:0] imm_s;
   logic signed [12:0] imm_b;
   logic signed [31:0] imm_u;
   logic signed [20:0] imm_j;

   assign imm_i = instr[31:20];
   assign imm_s = {instr[31:25], instr[11:7]};
   assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Select and sign-extend the immediate for the requested class
   always_comb begin
      imm = XLEN'(imm_i);
      case (immsrc)
         SRC_I, SRC_SH: imm = XLEN'(imm_i);
         SRC_S:         imm = XLEN'(imm_s);
         SRC_B:         imm = XLEN'(imm_b);
         SRC_U:         imm = XLEN'(imm_u);
         SRC_J:         imm = XLEN'(imm_j);
         default:       imm = XLEN'(imm_i);
      endcase
   end

endmodule

// File: rtl/decode_imm_sequencer.sv
// Decode front end: classifies fetched opcodes into an immediate class,
// extends the immediate, and holds up to two instructions in a skid buffer
// so ReadyF is a flop. Optional counters enabled by DECODE_PERF_CNT_EN.
// XLEN must be 32 or 64.
`timescale 1ns/1ps

module decode_imm_sequencer #(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] InstrF,
   input  logic                 ValidF,
   output logic                 ReadyF,
   input  logic                 FlushD,
   output logic [WORD_SIZE-1:0] InstrD,
   output logic [2:0]           ImmSrcD,
   output logic [XLEN-1:0]      ImmD,
   output logic                 ImmUsedD,
   output logic                 IllegalD,
   output logic                 ValidD,
   input  logic                 ReadyE
`ifdef DECODE_PERF_CNT_EN
   ,
   output logic [31:0]          AcceptCnt,
   output logic [31:0]          StallCnt
`endif
);

   localparam logic [2:0] SRC_I  = 3'd0;
   localparam logic [2:0] SRC_S  = 3'd1;
   localparam logic [2:0] SRC_B  = 3'd2;
   localparam logic [2:0] SRC_U  = 3'd3;
   localparam logic [2:0] SRC_J  = 3'd4;
   localparam logic [2:0] SRC_SH = 3'd5;

   localparam int unsigned SHW = $clog2(XLEN);
   localparam logic [XLEN-1:0] SHAMT_MASK   = XLEN'((64'd1 << SHW) - 64'd1);
   localparam logic [XLEN-1:0] SHAMT_MASK_W = XLEN'(32'h1F);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   typedef struct packed {
      logic [WORD_SIZE-1:0] instr;
      logic [2:0]           src;
      logic [XLEN-1:0]      imm;
      logic                 used;
      logic                 illegal;
   } entry_t;

   state_t          state;
   entry_t          head;
   entry_t          skid;
   entry_t          in_entry;
   logic [2:0]      cls_src;
   logic            cls_used;
   logic            cls_illegal;
   logic            cls_shw;
   logic [XLEN-1:0] ext_imm;
   logic            accept;
   logic            retire;

   assign accept = ValidF & ReadyF;
   assign retire = ValidD & ReadyE;

   // Opcode classification of the incoming instruction
   always_comb begin
      cls_src     = SRC_I;
      cls_used    = 1'b0;
      cls_illegal = 1'b0;
      cls_shw     = 1'b0;
      case (InstrF[6:0])
         7'b0010011: begin
            cls_used = 1'b1;
            if (InstrF[13:12] == 2'b01) cls_src = SRC_SH;
         end
         7'b0011011: begin
            cls_used = 1'b1;
            cls_shw  = 1'b1;
            if (InstrF[13:12] == 2'b01) cls_src = SRC_SH;
         end
         7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: cls_used = 1'b1;
         7'b0100011: begin cls_used = 1'b1; cls_src = SRC_S; end
         7'b0110111, 7'b0010111: begin cls_used = 1'b1; cls_src = SRC_U; end
         7'b1101111: begin cls_used = 1'b1; cls_src = SRC_J; end
         7'b1100011: begin cls_used = 1'b1; cls_src = SRC_B; end
         7'b0110011, 7'b0111011: cls_used = 1'b0;
         default: cls_illegal = 1'b1;
      endcase
   end

   imm_extend #(.XLEN(XLEN)) u_ext (
      .instr  (InstrF[31:7]),
      .immsrc (cls_src),
      .imm    (ext_imm)
   );

   // Assemble the entry to be registered; shift amounts keep only the shamt field
   always_comb begin
      in_entry.instr   = InstrF;
      in_entry.src     = cls_src;
      in_entry.used    = cls_used;
      in_entry.illegal = cls_illegal;
      in_entry.imm     = '0;
      if (cls_used) begin
         if (cls_src == SRC_SH)
            in_entry.imm = ext_imm & (cls_shw ? SHAMT_MASK_W : SHAMT_MASK);
         else
            in_entry.imm = ext_imm;
      end
   end

   // Skid-buffer sequencer: head is the output register, skid the second entry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= EMPTY;
         head   <= '0;
         skid   <= '0;
         ValidD <= 1'b0;
         ReadyF <= 1'b1;
      end else if (FlushD) begin
         state  <= EMPTY;
         ValidD <= 1'b0;
         ReadyF <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  head   <= in_entry;
                  ValidD <= 1'b1;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (accept && retire) begin
                  head <= in_entry;
               end else if (accept) begin
                  skid   <= in_entry;
                  state  <= FULL;
                  ReadyF <= 1'b0;
               end else if (retire) begin
                  ValidD <= 1'b0;
                  state  <= EMPTY;
               end
            end
            FULL: begin
               if (retire) begin
                  head   <= skid;
                  state  <= ONE;
                  ReadyF <= 1'b1;
               end
            end
            default: begin
               state  <= EMPTY;
               ValidD <= 1'b0;
               ReadyF <= 1'b1;
            end
         endcase
      end
   end

   assign InstrD   = head.instr;
   assign ImmSrcD  = head.src;
   assign ImmD     = head.imm;
   assign ImmUsedD = head.used;
   assign IllegalD = head.illegal;

`ifdef DECODE_PERF_CNT_EN
   // Saturating accept and stall counters; unaffected by flush
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         AcceptCnt <= '0;
         StallCnt  <= '0;
      end else begin
         if (accept && (AcceptCnt != 32'hFFFF_FFFF))
            AcceptCnt <= AcceptCnt + 32'd1;
         if (ValidF && !ReadyF && (StallCnt != 32'hFFFF_FFFF))
            StallCnt <= StallCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_decode_imm_sequencer.sv
// Directed bench for decode_imm_sequencer (XLEN=64).
`timescale 1ns/1ps

module tb_decode_imm_sequencer;

   localparam logic [2:0] IT = 3'd0;
   localparam logic [2:0] ST = 3'd1;
   localparam logic [2:0] BT = 3'd2;
   localparam logic [2:0] UT = 3'd3;
   localparam logic [2:0] JT = 3'd4;
   localparam logic [2:0] SH = 3'd5;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] InstrF;
   logic        ValidF;
   logic        ReadyF;
   logic        FlushD;
   logic [31:0] InstrD;
   logic [2:0]  ImmSrcD;
   logic [63:0] ImmD;
   logic        ImmUsedD;
   logic        IllegalD;
   logic        ValidD;
   logic        ReadyE;
`ifdef DECODE_PERF_CNT_EN
   logic [31:0] AcceptCnt;
   logic [31:0] StallCnt;
`endif

   int compared   = 0;
   int mismatched = 0;

   decode_imm_sequencer #(.XLEN(64), .WORD_SIZE(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .InstrF   (InstrF),
      .ValidF   (ValidF),
      .ReadyF   (ReadyF),
      .FlushD   (FlushD),
      .InstrD   (InstrD),
      .ImmSrcD  (ImmSrcD),
      .ImmD     (ImmD),
      .ImmUsedD (ImmUsedD),
      .IllegalD (IllegalD),
      .ValidD   (ValidD),
      .ReadyE   (ReadyE)
`ifdef DECODE_PERF_CNT_EN
      ,
      .AcceptCnt(AcceptCnt),
      .StallCnt (StallCnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"},   64'(ValidD),   64'd0);
      check({tag, "_ready"},   64'(ReadyF),   64'd1);
      check({tag, "_instr"},   64'(InstrD),   64'd0);
      check({tag, "_imm"},     ImmD,          64'd0);
      check({tag, "_src"},     64'(ImmSrcD),  64'(IT));
      check({tag, "_used"},    64'(ImmUsedD), 64'd0);
      check({tag, "_illegal"}, 64'(IllegalD), 64'd0);
   endtask

   logic [31:0] vec_instr [4];
   logic [2:0]  vec_src   [4];
   logic [63:0] vec_imm   [4];

   initial begin
      reset  = 1'b0;
      InstrF = '0;
      ValidF = 1'b0;
      FlushD = 1'b0;
      ReadyE = 1'b1;
      vec_instr = '{32'h0020A423, 32'hFFDFF06F, 32'h00000863, 32'h800000B7};
      vec_src   = '{ST, JT, BT, UT};
      vec_imm   = '{64'd8, 64'hFFFF_FFFF_FFFF_FFFC, 64'd16, 64'hFFFF_FFFF_8000_0000};

      repeat (2) tick();
      check_reset_values("rst");
      reset = 1'b1;
      tick();

      // addi x1,x0,-1
      InstrF = 32'hFFF00093; ValidF = 1'b1;
      tick();
      ValidF = 1'b0;
      check("addi_valid", 64'(ValidD),   64'd1);
      check("addi_instr", 64'(InstrD),   64'hFFF00093);
      check("addi_src",   64'(ImmSrcD),  64'(IT));
      check("addi_imm",   ImmD,          64'hFFFF_FFFF_FFFF_FFFF);
      check("addi_used",  64'(ImmUsedD), 64'd1);
      tick();
      check("addi_retired", 64'(ValidD), 64'd0);

      // slli x1,x1,63 then slliw x1,x1,31 back to back
      InstrF = 32'h03F09093; ValidF = 1'b1;
      tick();
      check("slli_src", 64'(ImmSrcD), 64'(SH));
      check("slli_imm", ImmD,          64'h3F);
      InstrF = 32'h01F0909B;
      tick();
      ValidF = 1'b0;
      check("slliw_src",   64'(ImmSrcD), 64'(SH));
      check("slliw_imm",   ImmD,         64'h1F);
      check("slliw_valid", 64'(ValidD),  64'd1);
      tick();

      // S/J/B/U stream, one per cycle in order
      for (int i = 0; i < 4; i++) begin
         InstrF = vec_instr[i]; ValidF = 1'b1;
         tick();
         check($sformatf("seq%0d_valid", i), 64'(ValidD),  64'd1);
         check($sformatf("seq%0d_instr", i), 64'(InstrD),  64'(vec_instr[i]));
         check($sformatf("seq%0d_src", i),   64'(ImmSrcD), 64'(vec_src[i]));
         check($sformatf("seq%0d_imm", i),   ImmD,         vec_imm[i]);
      end
      ValidF = 1'b0;
      tick();
      check("seq_drain", 64'(ValidD), 64'd0);

      // Backpressure: fill to FULL, hold, then drain in order
      ReadyE = 1'b0; ValidF = 1'b1; InstrF = 32'h00500113;
      tick();
      check("bp1_ready", 64'(ReadyF), 64'd1);
      check("bp1_instr", 64'(InstrD), 64'h00500113);
      InstrF = 32'h00700193;
      tick();
      check("bp2_ready", 64'(ReadyF), 64'd0);
      check("bp2_instr", 64'(InstrD), 64'h00500113);
      InstrF = 32'h00900213;
      tick();
      check("bp3_ready", 64'(ReadyF), 64'd0);
      check("bp3_instr", 64'(InstrD), 64'h00500113);
      tick();
      check("bp4_ready", 64'(ReadyF), 64'd0);
      check("bp4_imm",   ImmD,        64'd5);
      ReadyE = 1'b1; ValidF = 1'b0;
      tick();
      check("bp5_valid", 64'(ValidD), 64'd1);
      check("bp5_instr", 64'(InstrD), 64'h00700193);
      check("bp5_ready", 64'(ReadyF), 64'd1);
      check("bp5_imm",   ImmD,        64'd7);
      tick();
      check("bp6_valid", 64'(ValidD), 64'd0);

      // Flush while FULL together with an offered instruction
      ReadyE = 1'b0; ValidF = 1'b1; InstrF = 32'h00100093;
      tick();
      InstrF = 32'h00200093;
      tick();
      check("fl_full_ready", 64'(ReadyF), 64'd0);
      FlushD = 1'b1; InstrF = 32'h00300093; ReadyE = 1'b1;
      tick();
      FlushD = 1'b0; ValidF = 1'b0;
      check("fl_valid", 64'(ValidD), 64'd0);
      check("fl_ready", 64'(ReadyF), 64'd1);
      tick();
      check("fl_after_valid", 64'(ValidD), 64'd0);

      // R-type then illegal opcode
      InstrF = 32'h002081B3; ValidF = 1'b1;
      tick();
      check("rtype_used",    64'(ImmUsedD), 64'd0);
      check("rtype_imm",     ImmD,          64'd0);
      check("rtype_illegal", 64'(IllegalD), 64'd0);
      check("rtype_src",     64'(ImmSrcD),  64'(IT));
      InstrF = 32'h0000007F;
      tick();
      ValidF = 1'b0;
      check("ill_valid",   64'(ValidD),   64'd1);
      check("ill_illegal", 64'(IllegalD), 64'd1);
      check("ill_used",    64'(ImmUsedD), 64'd0);
      check("ill_imm",     ImmD,          64'd0);
      tick();

      // Fill to FULL, then drop reset asynchronously
      ReadyE = 1'b0; ValidF = 1'b1; InstrF = 32'h00A00293;
      tick();
      InstrF = 32'h00B00313;
      tick();
      ValidF = 1'b0;
      check("pre_rst_ready", 64'(ReadyF), 64'd0);
      check("pre_rst_valid", 64'(ValidD), 64'd1);
`ifdef DECODE_PERF_CNT_EN
      check("accept_cnt", 64'(AcceptCnt), 64'd15);
      check("stall_cnt",  64'(StallCnt),  64'd3);
`endif
      #2;
      reset = 1'b0;
      #1;
      check_reset_values("async_rst");
`ifdef DECODE_PERF_CNT_EN
      check("rst_accept_cnt", 64'(AcceptCnt), 64'd0);
      check("rst_stall_cnt",  64'(StallCnt),  64'd0);
`endif
      tick();
      reset = 1'b1;
      ReadyE = 1'b1;
      tick();
      check("post_rst_valid", 64'(ValidD), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
